// File: rtl/audio_source_arbiter.sv
// Mode/audio arbiter: debounces the mode selector, routes one sound source to the pins
// and inserts a silent gap of MUTE_CYCLES cycles on every switchover.
module audio_source_arbiter #(
  parameter int NUM_SRC         = 4,
  parameter int SEL_W           = 3,
  parameter int NOTE_W          = 4,
  parameter int LED_W           = 7,
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int MUTE_CYCLES     = 100000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SEL_W-1:0]          mode_select,
  input  logic [NUM_SRC-1:0]        src_speaker,
  input  logic [NUM_SRC*NOTE_W-1:0] src_note,
  input  logic [NUM_SRC*LED_W-1:0]  src_led,
  output logic [NUM_SRC-1:0]        src_enable,
  output logic                      speaker,
  output logic                      loud,
  output logic [NOTE_W-1:0]         note_out,
  output logic [LED_W-1:0]          led,
  output logic [SEL_W-1:0]          active_mode,
  output logic                      switching
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > MUTE_CYCLES) ? DEBOUNCE_CYCLES : MUTE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] MUTE_LAST = CW'(MUTE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [0:0] {ST_ACTIVE = 1'b0, ST_MUTE = 1'b1} state_t;

  function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] m);
    logic [NUM_SRC-1:0] v;
    v = {NUM_SRC{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      v[i] = (m == SEL_W'(i));
    end
    return v;
  endfunction

  logic [SEL_W-1:0]   sync1_r, sync2_r, cand_r, stable_r, mapped_s;
  logic [CW-1:0]      deb_cnt_r, deb_inc_s;
  state_t             state_r, state_next_s;
  logic [SEL_W-1:0]   target_r, target_next_s, mode_r, mode_next_s;
  logic [CW-1:0]      mute_cnt_r, mute_next_s;
  logic [NUM_SRC-1:0] mode_hot_s;
  logic               sel_speaker_s;
  logic [NOTE_W-1:0]  sel_note_s;
  logic [LED_W-1:0]   sel_led_s;
  logic               speaker_r, loud_r, switching_r;
  logic [NOTE_W-1:0]  note_r;
  logic [LED_W-1:0]   led_r;
  logic [NUM_SRC-1:0] enable_r;

  // Out-of-range selector codes fall back to free play.
  always_comb begin
    mapped_s = sync2_r;
    if (int'(sync2_r) >= NUM_SRC) begin
      mapped_s = {SEL_W{1'b0}};
    end else begin
      mapped_s = sync2_r;
    end
    deb_inc_s = (deb_cnt_r == DEB_LAST) ? deb_cnt_r : deb_cnt_r + CNT_ONE;
  end

  // Selector synchroniser and debounce; stable_sel updates as the counter reaches its last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r   <= {SEL_W{1'b0}};
      sync2_r   <= {SEL_W{1'b0}};
      cand_r    <= {SEL_W{1'b0}};
      stable_r  <= {SEL_W{1'b0}};
      deb_cnt_r <= {CW{1'b0}};
    end else begin
      sync1_r <= mode_select;
      sync2_r <= sync1_r;
      if (mapped_s != cand_r) begin
        cand_r    <= mapped_s;
        deb_cnt_r <= {CW{1'b0}};
      end else begin
        deb_cnt_r <= deb_inc_s;
        if (deb_inc_s == DEB_LAST) begin
          stable_r <= cand_r;
        end
      end
    end
  end

  // Source mux: AND-OR over the one-hot decode of the routed mode.
  always_comb begin
    mode_hot_s    = onehot(mode_r);
    sel_speaker_s = 1'b0;
    sel_note_s    = {NOTE_W{1'b0}};
    sel_led_s     = {LED_W{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_speaker_s = sel_speaker_s | (src_speaker[i] & mode_hot_s[i]);
      sel_note_s    = sel_note_s | (src_note[i*NOTE_W +: NOTE_W] & {NOTE_W{mode_hot_s[i]}});
      sel_led_s     = sel_led_s | (src_led[i*LED_W +: LED_W] & {LED_W{mode_hot_s[i]}});
    end
  end

  // Next-state logic: a new stable selection restarts the gap; returning to the routed mode aborts it.
  always_comb begin
    state_next_s  = state_r;
    target_next_s = target_r;
    mode_next_s   = mode_r;
    mute_next_s   = mute_cnt_r;
    case (state_r)
      ST_ACTIVE: begin
        mute_next_s = {CW{1'b0}};
        if (stable_r != mode_r) begin
          target_next_s = stable_r;
          state_next_s  = ST_MUTE;
        end else begin
          target_next_s = mode_r;
        end
      end
      ST_MUTE: begin
        if (stable_r != target_r) begin
          mute_next_s = {CW{1'b0}};
          if (stable_r == mode_r) begin
            target_next_s = mode_r;
            state_next_s  = ST_ACTIVE;
          end else begin
            target_next_s = stable_r;
          end
        end else if (mute_cnt_r == MUTE_LAST) begin
          mode_next_s  = target_r;
          state_next_s = ST_ACTIVE;
          mute_next_s  = {CW{1'b0}};
        end else begin
          mute_next_s = mute_cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_next_s  = ST_ACTIVE;
        target_next_s = mode_r;
        mute_next_s   = {CW{1'b0}};
      end
    endcase
  end

  // State and output registers; speaker only follows a source once ACTIVE has lasted a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_ACTIVE;
      target_r    <= {SEL_W{1'b0}};
      mode_r      <= {SEL_W{1'b0}};
      mute_cnt_r  <= {CW{1'b0}};
      speaker_r   <= 1'b0;
      loud_r      <= 1'b0;
      note_r      <= {NOTE_W{1'b0}};
      led_r       <= {LED_W{1'b0}};
      enable_r    <= onehot({SEL_W{1'b0}});
      switching_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      target_r    <= target_next_s;
      mode_r      <= mode_next_s;
      mute_cnt_r  <= mute_next_s;
      if ((state_r == ST_ACTIVE) && (state_next_s == ST_ACTIVE)) begin
        speaker_r <= sel_speaker_s;
        note_r    <= sel_note_s;
        led_r     <= sel_led_s;
      end else begin
        speaker_r <= 1'b0;
        note_r    <= {NOTE_W{1'b0}};
        led_r     <= {LED_W{1'b0}};
      end
      loud_r      <= (state_next_s == ST_ACTIVE);
      enable_r    <= (state_next_s == ST_ACTIVE) ? onehot(mode_next_s) : {NUM_SRC{1'b0}};
      switching_r <= (state_next_s == ST_MUTE);
    end
  end

  assign src_enable  = enable_r;
  assign speaker     = speaker_r;
  assign loud        = loud_r;
  assign note_out    = note_r;
  assign led         = led_r;
  assign active_mode = mode_r;
  assign switching   = switching_r;

endmodule

// File: tb/tb_audio_source_arbiter.sv
// Directed bench for audio_source_arbiter with short debounce/mute times; routed source
// data is checked through a scoreboard queue.
module tb_audio_source_arbiter;
  localparam int NS = 4;
  localparam int SW = 3;
  localparam int NW = 4;
  localparam int LW = 7;

  logic            clk = 1'b0;
  logic            reset;
  logic [SW-1:0]   mode_select;
  logic [NS-1:0]   src_speaker;
  logic [NS*NW-1:0] src_note;
  logic [NS*LW-1:0] src_led;
  logic [NS-1:0]   src_enable;
  logic            speaker, loud, switching;
  logic [NW-1:0]   note_out;
  logic [LW-1:0]   led;
  logic [SW-1:0]   active_mode;

  always #5 clk = ~clk;

  audio_source_arbiter #(
    .NUM_SRC(NS), .SEL_W(SW), .NOTE_W(NW), .LED_W(LW),
    .DEBOUNCE_CYCLES(4), .MUTE_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .mode_select(mode_select),
    .src_speaker(src_speaker), .src_note(src_note), .src_led(src_led),
    .src_enable(src_enable), .speaker(speaker), .loud(loud),
    .note_out(note_out), .led(led), .active_mode(active_mode), .switching(switching)
  );

  typedef struct packed {
    logic          spk;
    logic [NW-1:0] note;
    logic [LW-1:0] led;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_mode = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, ".enable"}, 32'(src_enable), 32'h1);
    chk({tag, ".mode"}, 32'(active_mode), 32'h0);
    chk({tag, ".spk"}, 32'(speaker), 32'h0);
    chk({tag, ".loud"}, 32'(loud), 32'h0);
    chk({tag, ".note"}, 32'(note_out), 32'h0);
    chk({tag, ".led"}, 32'(led), 32'h0);
    chk({tag, ".switching"}, 32'(switching), 32'h0);
  endtask

  // Drive fresh source data, queue what the routed source should show one cycle later.
  task automatic follow(input int n, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      src_speaker = 4'($urandom);
      src_note    = 16'($urandom);
      src_led     = 28'($urandom);
      sb.push_back({src_speaker[exp_mode], src_note[exp_mode*NW +: NW], src_led[exp_mode*LW +: LW]});
      @(negedge clk);
      e = sb.pop_front();
      chk({tag, ".spk"}, 32'(speaker), 32'(e.spk));
      chk({tag, ".note"}, 32'(note_out), 32'(e.note));
      chk({tag, ".led"}, 32'(led), 32'(e.led));
      chk({tag, ".loud"}, 32'(loud), 32'h1);
      chk({tag, ".switching"}, 32'(switching), 32'h0);
      chk({tag, ".enable"}, 32'(src_enable), 32'(4'b0001 << exp_mode));
      chk({tag, ".mode"}, 32'(active_mode), 32'(exp_mode));
    end
  endtask

  // Cycles from a selector change to the first MUTE cycle: 2 sync + 4 debounce + 1 FSM.
  task automatic wait_switch(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (switching !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic mute_len(input string tag, input int exp_len);
    int m;
    m = 0;
    while (switching === 1'b1 && m < 40) begin
      chk({tag, ".mute_loud"}, 32'(loud), 32'h0);
      chk({tag, ".mute_spk"}, 32'(speaker), 32'h0);
      chk({tag, ".mute_enable"}, 32'(src_enable), 32'h0);
      chk({tag, ".mute_note"}, 32'(note_out), 32'h0);
      @(negedge clk);
      m++;
    end
    chk({tag, ".mute_len"}, 32'(m), 32'(exp_len));
  endtask

  task automatic first_active(input string tag);
    chk({tag, ".first_mode"}, 32'(active_mode), 32'(exp_mode));
    chk({tag, ".first_enable"}, 32'(src_enable), 32'(4'b0001 << exp_mode));
    chk({tag, ".first_loud"}, 32'(loud), 32'h1);
    chk({tag, ".first_spk"}, 32'(speaker), 32'h0);
  endtask

  initial begin
    reset       = 1'b1;
    mode_select = 3'd0;
    src_speaker = 4'd0;
    src_note    = 16'd0;
    src_led     = 28'd0;
    @(negedge clk);
    @(negedge clk);
    reset_vals("reset");
    reset = 1'b0;
    follow(8, "mode0");

    // Three-cycle pulse is shorter than the debounce window.
    mode_select = 3'd1;
    follow(3, "glitch");
    mode_select = 3'd0;
    follow(12, "glitch_after");

    mode_select = 3'd2;
    wait_switch("sw02", 7);
    mute_len("sw02", 8);
    exp_mode = 2;
    first_active("sw02");
    follow(8, "mode2");

    mode_select = 3'd7;
    wait_switch("invalid", 7);
    mute_len("invalid", 8);
    exp_mode = 0;
    first_active("invalid");
    follow(6, "mode0b");

    // Selector returns to the routed mode during the gap.
    mode_select = 3'd2;
    wait_switch("abort", 7);
    mode_select = 3'd0;
    mute_len("abort", 7);
    first_active("abort");
    follow(4, "after_abort");

    // Redirect to 3 restarts the gap once the new code is stable.
    mode_select = 3'd2;
    wait_switch("redir", 7);
    mode_select = 3'd3;
    mute_len("redir", 15);
    exp_mode = 3;
    first_active("redir");
    follow(6, "mode3");

    // Reset during the fifth MUTE cycle.
    mode_select = 3'd1;
    wait_switch("rst_mute", 7);
    repeat (4) @(negedge clk);
    chk("rst_mute.in_mute", 32'(switching), 32'h1);
    reset = 1'b1;
    mode_select = 3'd0;
    @(negedge clk);
    reset_vals("rst_mute");
    reset = 1'b0;
    exp_mode = 0;
    follow(6, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
